// File: rtl/vector_input_fifo.sv
// Vector input FIFO: circular buffer of N-lane entries with eof tags and a one-cycle read latency.
// Optional IB_DROP_COUNT_EN adds a saturating 16-bit drop_count output.
module vector_input_fifo #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enqueue,
  input  logic                             eof_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  input  logic                             dequeue,
  output logic                             valid_out,
  output logic                             eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(IB_DEPTH):0]        occupancy,
  output logic                             overflow
`ifdef IB_DROP_COUNT_EN
  ,
  output logic [15:0]                      drop_count
`endif
);

  localparam int AW = $clog2(IB_DEPTH);

  logic [N-1:0][DATA_WIDTH-1:0] vec_mem [IB_DEPTH];
  logic                         eof_mem [IB_DEPTH];

  logic [AW-1:0]                head_q, head_d;
  logic [AW-1:0]                tail_q, tail_d;
  logic [AW:0]                  occ_q, occ_d;
  logic                         ovf_q, ovf_d;
  logic                         valid_q, valid_d;
  logic                         eof_q, eof_d;
  logic [N-1:0][DATA_WIDTH-1:0] vout_q, vout_d;

  logic accept, pop, drop;

  assign full      = (occ_q == (AW+1)'(IB_DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;
  assign overflow  = ovf_q;
  assign valid_out = valid_q;
  assign eof_out   = eof_q;
  assign vector_out = vout_q;

  // Full implies non-empty, so an enqueue at full with dequeue always frees a slot the same edge.
  assign pop    = dequeue && !empty;
  assign accept = enqueue && (!full || dequeue);
  assign drop   = enqueue && full && !dequeue;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    ovf_d   = ovf_q | drop;
    valid_d = pop;
    eof_d   = eof_q;
    vout_d  = vout_q;
    if (accept) head_d = head_q + AW'(1);
    if (pop) begin
      tail_d = tail_q + AW'(1);
      vout_d = vec_mem[tail_q];
      eof_d  = eof_mem[tail_q];
    end
    case ({accept, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      vout_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
      vout_q  <= vout_d;
    end
  end

  // Storage is left unreset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_mem[head_q] <= vector_in;
      eof_mem[head_q] <= eof_in;
    end
  end

`ifdef IB_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
